// File: rtl/pll_wrapper.sv
// pll_wrapper: divider-based clock generator with a lock timer.
// A free-running 4-bit divider provides clk/2..clk/16 candidates. The
// frequency select is only sampled when the divider wraps, so that every
// candidate bit is low at the switch point and no runt phase can occur.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_LOCKING  | lock timer running after reset release; pll_clk held low
// ST_LOCKED   | lock declared; pll_clk follows the selected divider bit
module pll_wrapper #(
  parameter int LOCK_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  output logic       pll_clk,
  output logic       pll_locked
);

  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

  typedef enum logic {
    ST_LOCKING = 1'b0,
    ST_LOCKED  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    div_cnt, div_nxt;
  logic [1:0]    act_sel, act_sel_nxt;
  logic [TW-1:0] lock_tmr, lock_tmr_nxt;
  logic          div_wrap;
  logic          pll_clk_nxt;

  // Divider advance and wrap-aligned selection update.
  always_comb begin
    div_nxt     = div_cnt + 4'd1;
    div_wrap    = (div_cnt == 4'hF);
    act_sel_nxt = div_wrap ? sel : act_sel;
  end

  // Lock sequencing: down-counting timer, lock on terminal count.
  always_comb begin
    state_nxt    = state;
    lock_tmr_nxt = lock_tmr;
    case (state)
      ST_LOCKING: begin
        lock_tmr_nxt = lock_tmr - TW'(1);
        if (lock_tmr == TW'(1)) begin
          state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        lock_tmr_nxt = '0;
      end
      default: begin
        state_nxt    = ST_LOCKING;
        lock_tmr_nxt = TW'(LOCK_CYCLES);
      end
    endcase
  end

  // Output clock gated by the current lock state, so the first high phase
  // starts one edge after pll_locked rises.
  always_comb begin
    pll_clk_nxt = 1'b0;
    if (state == ST_LOCKED) begin
      pll_clk_nxt = div_nxt[act_sel_nxt];
    end
  end

  // State, divider, selection and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOCKING;
      lock_tmr <= TW'(LOCK_CYCLES);
      div_cnt  <= 4'd0;
      act_sel  <= sel;
      pll_clk  <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_tmr <= lock_tmr_nxt;
      div_cnt  <= div_nxt;
      act_sel  <= act_sel_nxt;
      pll_clk  <= pll_clk_nxt;
    end
  end

  assign pll_locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_pll_wrapper.sv
// tb_pll_wrapper: directed scenarios plus randomized sel/rst activity,
// checked every cycle against a cycle-count based reference model.
module tb_pll_wrapper;

  localparam int LOCK = 256;

  logic       clk;
  logic       rst;
  logic [1:0] sel;
  logic       pll_clk;
  logic       pll_locked;

  int errors = 0;
  int checks = 0;

  // reference model: edges since reset release, and the selection in force
  int         m_k = 0;
  logic [1:0] m_act = 2'b00;
  bit         m_valid = 1'b0;
  logic       m_lock = 1'b0;
  logic       m_clk = 1'b0;

  pll_wrapper #(.LOCK_CYCLES(LOCK)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .pll_clk    (pll_clk),
    .pll_locked (pll_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge, then compare just after the edge.
  always @(posedge clk) begin
    logic       r_s;
    logic [1:0] s_s;
    logic [3:0] d;
    bit         prev_lock;
    r_s = rst;
    s_s = sel;
    if (r_s) begin
      m_k     = 0;
      m_act   = s_s;
      m_lock  = 1'b0;
      m_clk   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      prev_lock = (m_k >= LOCK);
      m_k       = m_k + 1;
      if (m_k % 16 == 0) m_act = s_s;
      d      = 4'(m_k % 16);
      m_lock = (m_k >= LOCK);
      m_clk  = prev_lock ? d[m_act] : 1'b0;
    end
    #1;
    if (m_valid) begin
      check("model_locked", int'(pll_locked), int'(m_lock));
      check("model_clk", int'(pll_clk), int'(m_clk));
    end
  end

  // Edges from now until pll_locked is seen high.
  task automatic wait_lock(output int n);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (pll_locked === 1'b1) break;
      if (n > LOCK + 100) begin
        n = -1;
        break;
      end
    end
  endtask

  // Period and high-phase length of pll_clk in clk cycles.
  task automatic measure(output int per, output int hi);
    logic prev;
    int   r1, r2, f1;
    r1 = -1; r2 = -1; f1 = -1;
    @(posedge clk);
    #1;
    prev = pll_clk;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!prev && pll_clk) begin
        if (r1 < 0) r1 = i;
        else begin
          r2 = i;
          break;
        end
      end
      if (prev && !pll_clk && r1 >= 0 && f1 < 0) f1 = i;
      prev = pll_clk;
    end
    per = (r1 >= 0 && r2 >= 0) ? r2 - r1 : -1;
    hi  = (r1 >= 0 && f1 >= 0) ? f1 - r1 : -1;
  endtask

  initial begin
    int n, per, hi;
    rst = 1'b1;
    sel = 2'b00;

    // 500 ns of reset
    repeat (50) @(negedge clk);
    check("reset_locked", int'(pll_locked), 0);
    check("reset_clk", int'(pll_clk), 0);

    rst = 1'b0;
    wait_lock(n);
    check("lock_latency", n, 256);

    repeat (10) @(negedge clk);
    measure(per, hi);
    check("period_sel0", per, 2);
    check("high_sel0", hi, 1);

    for (int s = 1; s < 4; s++) begin
      @(negedge clk);
      sel = 2'(s);
      repeat (40) @(negedge clk);
      measure(per, hi);
      check($sformatf("period_sel%0d", s), per, 2 << s);
      check($sformatf("high_sel%0d", s), hi, 1 << s);
      repeat (400) @(negedge clk);
    end

    // two sel changes inside one divider period: only the later one applies
    do @(negedge clk); while (m_k % 16 != 2);
    sel = 2'b01;
    repeat (3) @(negedge clk);
    sel = 2'b10;
    repeat (40) @(negedge clk);
    measure(per, hi);
    check("period_double_change", per, 8);

    // reset while locked at sel=11
    @(negedge clk);
    sel = 2'b11;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_locked", int'(pll_locked), 0);
    check("midreset_clk", int'(pll_clk), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_lock(n);
    check("relock_latency", n, 256);
    repeat (20) @(negedge clk);
    measure(per, hi);
    check("period_relock", per, 16);
    check("high_relock", hi, 8);

    // randomized sel changes and occasional reset pulses
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rst) begin
        if ($urandom_range(0, 2) == 0) rst = 1'b0;
      end else if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_wrapper.md
PLL_WRAPPER -- requirements
Module: pll_wrapper

Interface
REQ-001 Parameter LOCK_CYCLES, default 256, number of reference-clock cycles after reset release before lock is declared.
REQ-002 clk  input  1  reference clock, 100 MHz nominal; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sel  input  2  output-frequency select.
REQ-005 pll_clk  output  1  selected generated clock, registered.
REQ-006 pll_locked  output  1  lock indicator, registered.
REQ-007 The block SHALL have one clock (clk) and one reset (rst); the reset is synchronous and active-high.

Function
REQ-008 A free-running 4-bit divider counter SHALL increment by 1 on every clk edge and wrap 15 -> 0.
REQ-009 The four candidate clocks SHALL be the divider bits: sel=00 -> bit0 (clk/2, 50 MHz), 01 -> bit1 (clk/4, 25 MHz), 10 -> bit2 (clk/8, 12.5 MHz), 11 -> bit3 (clk/16, 6.25 MHz); all 50% duty.
REQ-010 The active selection SHALL be a registered copy of sel, loaded only on the edge where the divider wraps 15 -> 0; sel changes at any other time SHALL have no effect until the next wrap.
REQ-011 pll_clk SHALL be registered and equal the active-selection bit of the divider's new value, so pll_clk follows the selected divider bit with one register stage and no combinational path from sel.
REQ-012 Selection changes SHALL be glitch-free: every divider bit is 0 immediately after a wrap, so no pll_clk high or low phase shorter than one clk period (10 ns) occurs at a switch.
REQ-013 A lock counter SHALL count clk cycles from reset release and saturate; pll_locked SHALL go 1 on the edge completing LOCK_CYCLES cycles after the first edge with rst=0, and remain 1 until rst.
REQ-014 While pll_locked=0, pll_clk SHALL be held 0; the first pll_clk high phase SHALL begin no earlier than the edge after pll_locked rises.
REQ-015 sel SHALL be assumed synchronous to clk; no metastability synchronizer is required.

Reset
REQ-016 On any clk edge with rst=1: divider <= 0, lock counter <= 0, pll_locked <= 0, pll_clk <= 0, active selection <= sel.
REQ-017 rst asserted mid-operation SHALL drop pll_locked and force pll_clk low on that same edge; the full LOCK_CYCLES lock interval SHALL repeat after release.
REQ-018 Outputs are undefined only before the first clk edge with rst=1.

Verification
REQ-019 100 MHz clk, rst=1 for 500 ns, sel=00 -> pll_locked=0 and pll_clk=0 throughout reset.
REQ-020 Release rst at 500 ns -> pll_locked rises exactly 256 clk cycles later (2.56 us), pll_clk stays 0 before that, then toggles with 20 ns period.
REQ-021 After lock, sel=01, then 10, then 11, each held 5 us -> pll_clk period 40 ns, 80 ns, 160 ns respectively, each taking effect at the next divider wrap (within 160 ns of the sel change).
REQ-022 Glitch check across every switch above -> no pll_clk high or low pulse shorter than 10 ns; duty cycle 50% once settled.
REQ-023 Change sel twice within one divider period (e.g. 01 then 10 within 100 ns) -> only the value present at the wrap is applied; no intermediate frequency appears.
REQ-024 Assert rst for 3 cycles while locked at sel=11 -> pll_locked and pll_clk 0 on the first reset edge; after release, lock re-asserts 256 cycles later with 160 ns period.
